// File: rtl/cia_eclk_bus.sv
// cia_eclk_bus: 6800-style E-clock synchronised bus bridge between the CPU and the two CIAs.
module cia_eclk_bus (
  input  logic        clk,
  input  logic        _reset,
  input  logic [9:0]  eclk,
  input  logic        req,
  input  logic        rw,
  input  logic        sel_a,
  input  logic        sel_b,
  input  logic [15:0] cpu_din,
  output logic [15:0] cpu_dout,
  output logic        ack,
  output logic        vma,
  output logic        cia_e,
  output logic        cia_a_sel,
  output logic        cia_b_sel,
  output logic        cia_rw,
  output logic        cia_strobe,
  output logic [7:0]  cia_dout,
  input  logic [7:0]  cia_a_din,
  input  logic [7:0]  cia_b_din
);
  typedef enum logic [1:0] {IDLE, WAIT, ACTIVE, DONE} state_t;
  state_t state, nxt;
  logic enter;
  // dropping req aborts from any state; the E-period start (phase 2) opens the access window
  assign nxt = !req ? IDLE :
               (state == DONE) ? DONE :
               (state == ACTIVE) ? (eclk[9] ? DONE : ACTIVE) :
               (eclk[2] ? ACTIVE : WAIT);
  assign enter = (nxt == ACTIVE) && (state != ACTIVE);
  assign vma = state == ACTIVE;
  assign ack = state == DONE;
  assign cia_e = |eclk[9:6];
  assign cia_strobe = vma & eclk[9] & req;
  always_ff @(posedge clk or negedge _reset)
    if (!_reset) begin
      state     <= IDLE;
      cia_a_sel <= 1'b0;
      cia_b_sel <= 1'b0;
      cia_rw    <= 1'b1;
      cia_dout  <= 8'h00;
      cpu_dout  <= 16'hFFFF;
    end else begin
      state     <= nxt;
      cia_a_sel <= enter ? sel_a : (nxt == ACTIVE) & cia_a_sel;
      cia_b_sel <= enter ? sel_b : (nxt == ACTIVE) & cia_b_sel;
      if (enter) begin
        cia_rw   <= rw;
        cia_dout <= sel_a ? cpu_din[7:0] : cpu_din[15:8];
      end
      // unselected byte lanes float high on the CPU side
      if (cia_strobe && cia_rw)
        cpu_dout <= {cia_b_sel ? cia_b_din : 8'hFF, cia_a_sel ? cia_a_din : 8'hFF};
    end
endmodule

// File: tb/tb_cia_eclk_bus.sv
// tb_cia_eclk_bus: directed and randomized transactions checked against a transaction-level model.
module tb_cia_eclk_bus;
  logic clk = 0, rst_n = 0, req = 0, rw = 1, sel_a = 0, sel_b = 0;
  logic [15:0] cpu_din = 0, cpu_dout;
  logic ack, vma, cia_e, cia_a_sel, cia_b_sel, cia_rw, cia_strobe;
  logic [7:0] cia_dout, cia_a_din = 0, cia_b_din = 0;
  logic [9:0] eclk, eclk_f = 0;
  logic force_en = 0;
  int ph = 0;
  int checks = 0, failures = 0;
  logic [15:0] exp_dout = 16'hFFFF;

  cia_eclk_bus dut (
    .clk(clk), ._reset(rst_n), .eclk(eclk), .req(req), .rw(rw), .sel_a(sel_a), .sel_b(sel_b),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .ack(ack), .vma(vma), .cia_e(cia_e),
    .cia_a_sel(cia_a_sel), .cia_b_sel(cia_b_sel), .cia_rw(cia_rw), .cia_strobe(cia_strobe),
    .cia_dout(cia_dout), .cia_a_din(cia_a_din), .cia_b_din(cia_b_din)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ph <= (ph == 9) ? 0 : ph + 1;
  assign eclk = force_en ? eclk_f : 10'd1 << ph;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_ph(input int p);
    int g = 0;
    while (ph != p && g < 20) begin @(negedge clk); g++; end
  endtask

  task automatic chk_reset_vals();
    chk("rst_ack", ack, 0); chk("rst_vma", vma, 0); chk("rst_strobe", cia_strobe, 0);
    chk("rst_asel", cia_a_sel, 0); chk("rst_bsel", cia_b_sel, 0); chk("rst_rw", cia_rw, 1);
    chk("rst_cdout", cia_dout, 8'h00); chk("rst_cpudout", cpu_dout, 16'hFFFF);
  endtask

  // full transaction: p<0 means issue immediately at the current phase
  task automatic txn(input int p, input bit r, input bit sa, input bit sb, input logic [15:0] din,
                     input logic [7:0] ad, input logic [7:0] bd, input int hold);
    int n = 0, nv = 0, ns = 0, p0, lat;
    if (p >= 0) wait_ph(p);
    p0 = ph;
    lat = ((2 - p0 + 10) % 10) + 8;
    rw = r; sel_a = sa; sel_b = sb; cpu_din = din; cia_a_din = ad; cia_b_din = bd; req = 1;
    if (r) exp_dout = {sb ? bd : 8'hFF, sa ? ad : 8'hFF};
    while (!ack && n < 40) begin
      @(negedge clk); n++;
      if (vma) begin
        if (nv == 0) begin
          chk("act_rw", cia_rw, r); chk("act_asel", cia_a_sel, sa); chk("act_bsel", cia_b_sel, sb);
          chk("act_cdout", cia_dout, sa ? din[7:0] : din[15:8]);
        end
        nv++;
      end
      if (cia_strobe) ns++;
    end
    chk("latency", n, lat); chk("vma_clks", nv, 7); chk("strobes", ns, 1);
    chk("cpu_dout", cpu_dout, exp_dout);
    chk("done_asel", cia_a_sel, 0); chk("done_bsel", cia_b_sel, 0);
    cia_a_din = 8'($urandom); cia_b_din = 8'($urandom);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_ack", ack, 1); chk("hold_strobe", cia_strobe, 0); chk("hold_dout", cpu_dout, exp_dout);
    end
    req = 0;
    @(negedge clk);
    chk("rel_ack", ack, 0); chk("rel_vma", vma, 0);
  endtask

  task automatic abort_at(input int drop_ph);
    int ns = 0, na = 0;
    wait_ph(2);
    rw = 1; sel_a = 1; sel_b = 1; cia_a_din = 8'h11; cia_b_din = 8'h22; req = 1;
    @(negedge clk);
    wait_ph(drop_ph);
    chk("ab_vma", vma, 1);
    req = 0;
    #1 chk("ab_strobe", cia_strobe, 0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (cia_strobe) ns++;
      if (ack) na++;
      if (i == 0) chk("ab_idle", vma, 0);
    end
    chk("ab_nstrobe", ns, 0); chk("ab_nack", na, 0); chk("ab_dout", cpu_dout, exp_dout);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_vals();
    rst_n = 1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin @(negedge clk); chk("cia_e", cia_e, ph >= 6); end
    txn(2, 1, 1, 0, 16'h0000, 8'h5A, 8'h77, 0);
    chk("read_a", cpu_dout, 16'hFF5A);
    txn(3, 0, 0, 1, 16'hC300, 8'h00, 8'h00, 2);
    chk("write_keep", cpu_dout, 16'hFF5A);
    txn(5, 1, 1, 1, 16'hBEEF, 8'hA1, 8'hB2, 1);
    txn(-1, 1, 0, 0, 16'h1234, 8'h33, 8'h44, 0);
    chk("nosel", cpu_dout, 16'hFFFF);
    txn(-1, 1, 0, 1, 16'h0000, 8'h55, 8'h66, 0);
    abort_at(7);
    abort_at(9);
    txn(9, 1, 1, 0, 16'h0000, 8'h99, 8'h00, 50);
    txn(-1, 1, 0, 1, 16'h0000, 8'h00, 8'h3C, 0);
    // reset mid-ACTIVE
    wait_ph(2);
    rw = 1; sel_a = 1; sel_b = 0; req = 1;
    @(negedge clk);
    wait_ph(5);
    chk("pre_rst_vma", vma, 1);
    rst_n = 0;
    #1 chk_reset_vals();
    chk("rst_cia_e", cia_e, ph >= 6);
    exp_dout = 16'hFFFF;
    repeat (2) @(negedge clk);
    req = 0; rst_n = 1;
    @(negedge clk);
    chk("post_rst_vma", vma, 0); chk("post_rst_ack", ack, 0);
    txn(-1, 1, 1, 0, 16'h0000, 8'hE1, 8'h00, 0);
    txn(-1, 1, 0, 1, 16'h0000, 8'h00, 8'hE2, 0);
    // multi-hot eclk: phases 2 and 9 at once act per bit
    @(negedge clk);
    force_en = 1; eclk_f = 10'b1000000100;
    rw = 0; sel_a = 1; sel_b = 0; cpu_din = 16'h00D7; req = 1;
    @(negedge clk);
    chk("mh_vma", vma, 1); chk("mh_strobe", cia_strobe, 1); chk("mh_cdout", cia_dout, 8'hD7);
    chk("mh_cia_e", cia_e, 1);
    @(negedge clk);
    chk("mh_ack", ack, 1);
    req = 0; force_en = 0;
    @(negedge clk);
    chk("mh_idle", ack, 0);
    for (int k = 0; k < 20; k++)
      txn(($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 9)), 1'($urandom), 1'($urandom),
          1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
